// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared DataMemory widths and arbiter FSM encodings.
package dmem_arbiter_pkg;
    localparam int DMEM_AW = 16;
    localparam int DMEM_DW = 16;
    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// dmem_arbiter_rr_pick: combinational winner select (round-robin after last, or lowest index
// when DMEM_ARB_FIXED_PRIO_EN is defined).
module dmem_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last;
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx = IW'(k);
                any = 1'b1;
            end
        end
        onehot = any ? (N'(1) << idx) : '0;
    end
`else
    // Scan from farthest to nearest so the core right after last overwrites everyone else.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                idx = IW'((int'(last) + k) % N);
                any = 1'b1;
            end
        end
        onehot = any ? (N'(1) << idx) : '0;
    end
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one synchronous DataMemory port between N cores.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int N_CORES    = 4,
    parameter int AW         = DMEM_AW,
    parameter int DW         = DMEM_DW,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CORES-1:0]    core_req,
    input  logic [N_CORES-1:0]    core_we,
    input  logic [N_CORES*AW-1:0] core_addr,
    input  logic [N_CORES*DW-1:0] core_wdata,
    output logic [N_CORES-1:0]    core_gnt,
    output logic [N_CORES-1:0]    core_rvalid,
    output logic [DW-1:0]         core_rdata,
    output logic                  mem_wren,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_din,
    input  logic [DW-1:0]         mem_q
);
    localparam int IW = $clog2(N_CORES);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam logic [IW-1:0] RR_RST = '0;
`else
    localparam logic [IW-1:0] RR_RST = IW'(N_CORES - 1);
`endif
    logic [1:0]         state;
    logic [1:0]         cnt;
    logic [IW-1:0]      rr_last;
    logic [IW-1:0]      w;
    logic [IW-1:0]      pick_idx;
    logic [N_CORES-1:0] pick_oh;
    logic               pick_any;

    dmem_arbiter_rr_pick #(.N(N_CORES), .IW(IW)) u_pick (
        .req    (core_req),
        .last   (rr_last),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // mem_wren stays high through ISSUE, so it doubles as the write/read flag there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            cnt         <= '0;
            rr_last     <= RR_RST;
            w           <= '0;
            core_gnt    <= '0;
            core_rvalid <= '0;
            core_rdata  <= '0;
            mem_wren    <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
        end else begin
            core_gnt    <= '0;
            core_rvalid <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        w        <= pick_idx;
                        mem_addr <= core_addr[pick_idx*AW +: AW];
                        mem_din  <= core_wdata[pick_idx*DW +: DW];
                        mem_wren <= core_we[pick_idx];
                        core_gnt <= pick_oh;
                        state    <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    mem_wren <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    rr_last  <= w;
`endif
                    cnt      <= 2'(RD_LATENCY - 1);
                    state    <= mem_wren ? ARB_IDLE : ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (cnt == '0) begin
                        core_rvalid[w] <= 1'b1;
                        core_rdata     <= mem_q;
                        state          <= ARB_IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a behavioural 1-cycle DataMemory, N_CORES=4, RD_LATENCY=1.
module tb_dmem_arbiter;
    localparam int N = 4;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        int          core;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0] gnt, rvalid;
    logic [DW-1:0] rdata, mem_din, mem_q;
    logic [AW-1:0] mem_addr;
    logic mem_wren;
    logic [15:0] mem [0:65535];
    int n_cmp = 0;
    int n_bad = 0;
    txn_t tbl [6];

    always #5 clk = ~clk;

    dmem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .RD_LATENCY(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_req    (req),
        .core_we     (we),
        .core_addr   (addr),
        .core_wdata  (wdata),
        .core_gnt    (gnt),
        .core_rvalid (rvalid),
        .core_rdata  (rdata),
        .mem_wren    (mem_wren),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_q       (mem_q)
    );

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_din;
        mem_q <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int c, input logic w, input logic [15:0] a, input logic [15:0] d);
        req[c] = 1'b1;
        we[c] = w;
        addr[c*AW +: AW] = a;
        wdata[c*DW +: DW] = d;
    endtask

    task automatic wait_gnt();
        logic ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = (gnt != '0);
        end
        chk("gnt_timeout", 32'(ok), 32'd1);
    endtask

    task automatic do_txn(input txn_t t);
        put(t.core, t.we, t.addr, t.wdata);
        wait_gnt();
        chk("txn_gnt", 32'(gnt), 32'(4'b1 << t.core));
        chk("txn_wren", 32'(mem_wren), 32'(t.we));
        chk("txn_addr", 32'(mem_addr), 32'(t.addr));
        if (t.we) chk("txn_din", 32'(mem_din), 32'(t.wdata));
        req[t.core] = 1'b0;
        tick();
        chk("txn_early_rvalid", 32'(rvalid), 32'd0);
        if (!t.we) begin
            tick();
            chk("txn_rvalid", 32'(rvalid), 32'(4'b1 << t.core));
            chk("txn_rdata", 32'(rdata), 32'(t.exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        int got, last_cyc;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        tbl[0] = '{1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        tbl[1] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[2] = '{0, 1'b1, 16'h0005, 16'h5555, 16'h0000};
        tbl[3] = '{2, 1'b0, 16'h0005, 16'h0000, 16'h5555};
        tbl[4] = '{3, 1'b1, 16'hFFFF, 16'hA5A5, 16'h0000};
        tbl[5] = '{3, 1'b0, 16'hFFFF, 16'h0000, 16'hA5A5};

        // reset state
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_wren", 32'(mem_wren), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_no_gnt", 32'(gnt), 32'd0);

        for (int i = 0; i < 6; i++) do_txn(tbl[i]);

        // async reset while a read is in WAIT
        put(2, 1'b0, 16'h0033, 16'h7777);
        wait_gnt();
        chk("rw_gnt", 32'(gnt), 32'b0100);
        req[2] = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rw_gnt0", 32'(gnt), 32'd0);
        chk("rw_rvalid0", 32'(rvalid), 32'd0);
        chk("rw_wren0", 32'(mem_wren), 32'd0);
        chk("rw_addr0", 32'(mem_addr), 32'd0);
        chk("rw_din0", 32'(mem_din), 32'd0);
        chk("rw_rdata0", 32'(rdata), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | (rvalid != '0) | (gnt != '0);
        end
        chk("rw_no_late_rvalid", 32'(seen), 32'd0);
        put(0, 1'b0, 16'h0010, 16'h0000);
        put(3, 1'b0, 16'h0010, 16'h0000);
        wait_gnt();
        chk("rw_first_core0", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        tick();
        chk("rw_rvalid_core0", 32'(rvalid), 32'b0001);
        chk("rw_rdata_core0", 32'(rdata), 32'hBEEF);
        do_txn(tbl[5]);

`ifdef DMEM_ARB_FIXED_PRIO_EN
        put(0, 1'b0, 16'h0010, 16'h0000);
        put(3, 1'b0, 16'h0005, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            wait_gnt();
            chk("fp_gnt", 32'(gnt), 32'b0001);
        end
        req = '0;
        for (int i = 0; i < 4; i++) tick();
`else
        // all four cores read continuously: rotation 0,1,2,3 with 3-cycle spacing
        for (int c = 0; c < N; c++) put(c, 1'b0, 16'(16'h0100 + c), 16'h0000);
        got = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            tick();
            if (gnt != '0) begin
                chk("rr_gnt", 32'(gnt), 32'(4'b1 << (got % 4)));
                if (got > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                got++;
            end
        end
        chk("rr_count", 32'(got), 32'd8);
        req = '0;
        for (int i = 0; i < 4; i++) tick();
`endif

        // core2 read races core3 write to the same address
        put(2, 1'b0, 16'h0005, 16'h0000);
        put(3, 1'b1, 16'h0005, 16'h1234);
        wait_gnt();
        chk("race_gnt2", 32'(gnt), 32'b0100);
        req[2] = 1'b0;
        tick();
        tick();
        chk("race_rvalid2", 32'(rvalid), 32'b0100);
        chk("race_old_data", 32'(rdata), 32'h5555);
        wait_gnt();
        chk("race_gnt3", 32'(gnt), 32'b1000);
        chk("race_wren", 32'(mem_wren), 32'd1);
        chk("race_din", 32'(mem_din), 32'h1234);
        req[3] = 1'b0;
        tick();
        do_txn('{2, 1'b0, 16'h0005, 16'h0000, 16'h1234});

        // core0 requests while busy and withdraws before any grant
        put(1, 1'b0, 16'h0010, 16'h0000);
        wait_gnt();
        chk("wd_gnt1", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        put(0, 1'b0, 16'h0000, 16'h0000);
        tick();
        req[0] = 1'b0;
        tick();
        chk("wd_rvalid1", 32'(rvalid), 32'b0010);
        chk("wd_rdata1", 32'(rdata), 32'hBEEF);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen = seen | gnt[0] | rvalid[0];
        end
        chk("wd_core0_never", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
